// File: rtl/acc_mem_pkg.sv
// acc_mem_pkg: shared types and default widths for the accelerator memory arbiter
package acc_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {READ, WRITE} arb_op_t;
  localparam int ADDR_W = 16;
  localparam int RD_W = 512;
  localparam int WR_W = 32;
endpackage

// File: rtl/acc_rr_pick.sv
// acc_rr_pick: combinational round-robin picker, first pending requester at or after rr_ptr
module acc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IW-1:0]      rr_ptr,
  output logic               found,
  output logic [IW-1:0]      winner
);
  logic [IW-1:0] idx;
  // scanning from the farthest offset down leaves the nearest pending one as winner
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (pending[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: round-robin serialization of accelerator reads/writes onto one memory port
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_SIZE = ADDR_W,
  parameter int RD_DATA_SIZE = RD_W,
  parameter int WR_DATA_SIZE = WR_W,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_read_en,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]    req_read_addr,
  input  logic [NUM_REQ-1:0]              req_write_en,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]    req_write_addr,
  input  logic [NUM_REQ*WR_DATA_SIZE-1:0] req_write_data,
  output logic [RD_DATA_SIZE-1:0]         req_read_data,
  output logic [NUM_REQ-1:0]              req_read_data_valid,
  output logic [NUM_REQ-1:0]              req_write_done,
  output logic                            mem_en,
  output logic                            mem_wr,
  output logic [ADDR_SIZE-1:0]            mem_addr,
  output logic [WR_DATA_SIZE-1:0]         mem_wdata,
  input  logic [RD_DATA_SIZE-1:0]         mem_rdata,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MEM_RD_LATENCY + 1);
  arb_state_t state, state_n;
  arb_op_t op_q;
  logic [IW-1:0] id_q, rr_ptr, winner;
  logic found;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [WR_DATA_SIZE-1:0] wdata_q;
  logic [RD_DATA_SIZE-1:0] rdata_q;
  logic [CW-1:0] cnt;
  logic [ADDR_SIZE-1:0] rd_addr [NUM_REQ];
  logic [ADDR_SIZE-1:0] wr_addr [NUM_REQ];
  logic [WR_DATA_SIZE-1:0] wr_data [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign rd_addr[i] = req_read_addr[i*ADDR_SIZE +: ADDR_SIZE];
    assign wr_addr[i] = req_write_addr[i*ADDR_SIZE +: ADDR_SIZE];
    assign wr_data[i] = req_write_data[i*WR_DATA_SIZE +: WR_DATA_SIZE];
  end
  acc_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .pending(req_read_en | req_write_en),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );
  always_comb begin
    state_n = state == IDLE  ? (found ? ISSUE : IDLE) :
              state == ISSUE ? (op_q == WRITE ? DONE : WAIT) :
              state == WAIT  ? (cnt == CW'(MEM_RD_LATENCY) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      id_q <= '0;
      op_q <= READ;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        id_q <= winner;
        op_q <= req_read_en[winner] ? READ : WRITE;
        addr_q <= req_read_en[winner] ? rd_addr[winner] : wr_addr[winner];
        wdata_q <= wr_data[winner];
      end
      cnt <= state == WAIT ? cnt + 1'b1 : CW'(1);
      if (state == WAIT && cnt == CW'(MEM_RD_LATENCY)) rdata_q <= mem_rdata;
      if (state == DONE) rr_ptr <= id_q == IW'(NUM_REQ - 1) ? '0 : id_q + 1'b1;
    end
  end
  assign mem_en = state == ISSUE;
  assign mem_wr = mem_en && op_q == WRITE;
  assign mem_addr = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign req_read_data = rdata_q;
  assign req_read_data_valid = (state == DONE && op_q == READ) ? NUM_REQ'(1) << id_q : '0;
  assign req_write_done = (state == DONE && op_q == WRITE) ? NUM_REQ'(1) << id_q : '0;
  assign busy = state != IDLE;
  assign grant_id = id_q;
endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb_acc_mem_arbiter: directed checks of arbitration order, timing, read capture and reset
module tb_acc_mem_arbiter;
  localparam int N = 4;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] rd_en, wr_en, valid, done;
  logic [N*16-1:0] rd_addr, wr_addr;
  logic [N*32-1:0] wr_data;
  logic [511:0] rdata;
  logic [511:0] mem_rdata = '0;
  logic mem_en, mem_wr, busy;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_mem_arbiter #(.NUM_REQ(N), .MEM_RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_read_en(rd_en), .req_read_addr(rd_addr),
    .req_write_en(wr_en), .req_write_addr(wr_addr), .req_write_data(wr_data),
    .req_read_data(rdata), .req_read_data_valid(valid), .req_write_done(done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  function automatic logic [511:0] pat(logic [15:0] a);
    return {16{16'hC0DE, a}};
  endfunction

  always @(posedge clk) if (mem_en && !mem_wr) mem_rdata <= pat(mem_addr);

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r, w, n;
    logic got;
    logic [15:0] a;
    rst = 1'b1;
    rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    ticks(2);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pulses", {valid, done}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) begin
      wr_addr[i*16 +: 16] = 16'h0100 + 16'(i);
      wr_data[i*32 +: 32] = 32'hA0 + 32'(i);
    end
    wr_en = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", grant_id, k % 4);
      check("rr_wdata", mem_wdata, 32'hA0 + k % 4);
      tick();
      check("rr_done", done, 4'b0001 << (k % 4));
      if (k == 4) wr_en = '0;
      tick();
    end
    check("rr_idle", busy, 0);
    tick();
    check("rr_no_extra", {mem_en, busy}, 0);

    wr_addr[31:16] = 16'h5000;
    wr_data[63:32] = 32'h5;
    wr_en = 4'b0010;
    tick();
    check("wr_mem_en", {mem_en, mem_wr}, 2'b11);
    check("wr_addr", mem_addr, 16'h5000);
    check("wr_data", mem_wdata, 32'h5);
    check("wr_grant", grant_id, 1);
    tick();
    check("wr_done", done, 4'b0010);
    wr_en = '0;
    tick();
    check("wr_busy_after", busy, 0);
    check("wr_done_after", done, 0);

    rd_addr[15:0] = 16'h1000;
    rd_en = 4'b0001;
    tick();
    check("rd_mem_en", {mem_en, mem_wr}, 2'b10);
    check("rd_addr", mem_addr, 16'h1000);
    ticks(3);
    check("rd_valid_early", valid, 0);
    tick();
    check("rd_valid", valid, 4'b0001);
    check("rd_data", rdata, pat(16'h1000));
    rd_en = '0;
    ticks(10);
    check("rd_data_hold", rdata, pat(16'h1000));
    check("rd_valid_gone", valid, 0);

    rd_addr[47:32] = 16'h2000;
    wr_addr[47:32] = 16'h3000;
    wr_data[95:64] = 32'hDEAD;
    rd_en = 4'b0100;
    wr_en = 4'b0100;
    tick();
    check("both_rd_first", {mem_en, mem_wr}, 2'b10);
    check("both_rd_addr", mem_addr, 16'h2000);
    ticks(4);
    check("both_rd_pulse", {valid, done}, {4'b0100, 4'b0000});
    check("both_rd_data", rdata, pat(16'h2000));
    rd_en = '0;
    ticks(2);
    check("both_wr_issue", {mem_en, mem_wr}, 2'b11);
    check("both_wr_addr", mem_addr, 16'h3000);
    check("both_wr_data", mem_wdata, 32'hDEAD);
    tick();
    check("both_wr_done", {valid, done}, {4'b0000, 4'b0100});
    wr_en = '0;
    tick();

    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, N - 1);
      w = $urandom_range(0, 1);
      a = 16'($urandom);
      n = 0;
      got = 1'b0;
      if (w == 1) begin
        wr_addr[r*16 +: 16] = a;
        wr_en[r] = 1'b1;
      end else begin
        rd_addr[r*16 +: 16] = a;
        rd_en[r] = 1'b1;
      end
      for (int c = 0; c < 12 && !got; c++) begin
        tick();
        if (mem_en) n++;
        got = |{valid, done};
      end
      check("rand_pulse", {valid, done}, w == 1 ? {4'b0, 4'b0001 << r} : {4'b0001 << r, 4'b0});
      rd_en = '0;
      wr_en = '0;
      for (int c = 0; c < 2; c++) begin
        tick();
        if (mem_en) n++;
      end
      check("rand_one_access", n, 1);
    end

    rd_addr[31:16] = 16'h4444;
    rd_en = 4'b0010;
    ticks(2);
    check("mid_in_wait", {busy, mem_en}, 2'b10);
    rst = 1'b1;
    rd_en = '0;
    tick();
    check("mid_busy", busy, 0);
    check("mid_mem", {mem_en, mem_wr, mem_addr, mem_wdata}, 0);
    check("mid_pulses", {valid, done}, 0);
    check("mid_rdata", rdata, 0);
    check("mid_grant", grant_id, 0);
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      got = got | (|{valid, done, busy});
    end
    check("mid_quiet", got, 0);
    wr_addr[63:48] = 16'h7777;
    wr_data[127:96] = 32'h77;
    wr_en = 4'b1000;
    tick();
    check("post_grant", grant_id, 3);
    check("post_addr", mem_addr, 16'h7777);
    tick();
    check("post_done", done, 4'b1000);
    wr_en = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
